// File: rtl/mor1kx_trace_collector.sv
`default_nettype none
// ============================================================================
//  Module   : mor1kx_trace_collector
//  Purpose  : Collects per-core execution-trace events into per-channel
//             FIFOs with drop accounting and merges them round-robin into
//             a single registered valid/ready record stream.
//  Revision : 1.0 - initial release
// ============================================================================
module mor1kx_trace_collector #(
    parameter int    NUM_CH      = 1,
    parameter int    FIFO_DEPTH  = 8,
    parameter string FILTER_MODE = "ALL"
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [NUM_CH-1:0]      trace_valid_i,
    input  logic [32*NUM_CH-1:0]   trace_pc_i,
    input  logic [32*NUM_CH-1:0]   trace_insn_i,
    input  logic [32*NUM_CH-1:0]   trace_wbdata_i,
    input  logic [NUM_CH-1:0]      trace_jb_i,
    input  logic [NUM_CH-1:0]      trace_wben_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [100:0]           out_data_o,
    output logic                   drop_any_o
);

    localparam int c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ENTRY_W = 98;           // {kind[1:0], pc, insn, wbdata}
    localparam int c_MAX_CH  = 8;
    localparam bit c_JUMPS   = (FILTER_MODE == "JUMPS");
    localparam bit c_WB      = (FILTER_MODE == "WB");

    // Per-channel views padded to the maximum channel count so the arbiter
    // can index them with a fixed 3-bit channel number.
    logic [c_ENTRY_W-1:0] w_head [c_MAX_CH];
    logic [c_MAX_CH-1:0]  w_nonempty;
    logic [c_MAX_CH-1:0]  w_pop;
    logic [NUM_CH-1:0]    w_drop_evt;

    logic       r_out_valid;
    logic [100:0] r_out_data;
    logic       r_drop_any;
    logic [2:0] r_rr_ptr;
    logic [2:0] w_grant;
    logic [3:0] w_idx;
    logic       w_found;
    logic       w_load;

    logic w_unused;
    assign w_unused = ^trace_wben_i;

    generate
        for (genvar c = 0; c < c_MAX_CH; c++) begin : g_ch
            if (c < NUM_CH) begin : g_live
                logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
                logic [c_AW-1:0]      r_wr_ptr;
                logic [c_AW-1:0]      r_rd_ptr;
                logic [c_CW-1:0]      r_count;
                logic [15:0]          r_drop_cnt;
                logic [c_CW-1:0]      w_free;
                logic                 w_filt;
                logic                 w_qual;
                logic                 w_wr_ovf;
                logic                 w_wr_evt;
                logic                 w_drop_inc;
                logic                 w_drop_set1;
                logic                 w_drop_clr;
                logic [c_ENTRY_W-1:0] w_evt;
                logic [c_ENTRY_W-1:0] w_ovf;

                assign w_filt = c_JUMPS ? trace_jb_i[c] :
                                (c_WB ? trace_wben_i[c] : 1'b1);
                assign w_qual = enable_i & trace_valid_i[c] & w_filt;
                // Free space is taken from the start-of-cycle occupancy, so a
                // concurrent pop never makes room for this cycle's write.
                assign w_free = c_CW'(FIFO_DEPTH) - r_count;
                assign w_evt  = {(trace_jb_i[c] ? 2'd1 : 2'd0),
                                 trace_pc_i[32*c +: 32],
                                 trace_insn_i[32*c +: 32],
                                 trace_wbdata_i[32*c +: 32]};
                assign w_ovf  = {2'd2, 32'h0, 32'h0, 16'h0, r_drop_cnt};

                assign w_head[c]     = r_mem[r_rd_ptr];
                assign w_nonempty[c] = (r_count != '0);
                assign w_drop_evt[c] = w_drop_inc | w_drop_set1;

                // Decide what a qualified event writes: event only, overflow
                // marker plus event, marker only, or nothing (counted drop).
                always_comb begin
                    w_wr_ovf    = 1'b0;
                    w_wr_evt    = 1'b0;
                    w_drop_inc  = 1'b0;
                    w_drop_set1 = 1'b0;
                    w_drop_clr  = 1'b0;
                    if (w_qual) begin
                        if (r_drop_cnt == 16'h0) begin
                            if (w_free != '0) w_wr_evt   = 1'b1;
                            else              w_drop_inc = 1'b1;
                        end else if (w_free >= c_CW'(2)) begin
                            w_wr_ovf   = 1'b1;
                            w_wr_evt   = 1'b1;
                            w_drop_clr = 1'b1;
                        end else if (w_free == c_CW'(1)) begin
                            w_wr_ovf    = 1'b1;
                            w_drop_set1 = 1'b1;
                        end else begin
                            w_drop_inc = 1'b1;
                        end
                    end
                end

                // FIFO storage, pointers, occupancy and saturating drop count.
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_count    <= '0;
                        r_drop_cnt <= 16'h0;
                    end else begin
                        if (w_wr_ovf) begin
                            r_mem[r_wr_ptr] <= w_ovf;
                            if (w_wr_evt) r_mem[r_wr_ptr + c_AW'(1)] <= w_evt;
                        end else if (w_wr_evt) begin
                            r_mem[r_wr_ptr] <= w_evt;
                        end
                        r_wr_ptr <= r_wr_ptr + c_AW'(w_wr_ovf) + c_AW'(w_wr_evt);
                        if (w_pop[c]) r_rd_ptr <= r_rd_ptr + c_AW'(1);
                        r_count <= r_count + c_CW'(w_wr_ovf) + c_CW'(w_wr_evt)
                                   - c_CW'(w_pop[c]);
                        if (w_drop_clr)
                            r_drop_cnt <= 16'h0;
                        else if (w_drop_set1)
                            r_drop_cnt <= 16'h1;
                        else if (w_drop_inc && r_drop_cnt != 16'hFFFF)
                            r_drop_cnt <= r_drop_cnt + 16'h1;
                    end
                end
            end else begin : g_pad
                assign w_head[c]     = '0;
                assign w_nonempty[c] = 1'b0;
            end
        end
    endgenerate

    // Round-robin search: first non-empty channel at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_rr_ptr;
        w_idx   = 4'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(i);
            if (w_idx >= 4'(NUM_CH)) w_idx = w_idx - 4'(NUM_CH);
            if (!w_found && w_nonempty[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[2:0];
            end
        end
    end

    assign w_load = w_found & (~r_out_valid | out_ready_i);

    // Pop strobe goes only to the granted channel when the output reloads.
    always_comb begin
        w_pop = '0;
        if (w_load) w_pop[w_grant] = 1'b1;
    end

    // Output register, arbiter pointer and sticky drop flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rr_ptr    <= 3'd0;
            r_drop_any  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= {w_grant, w_head[w_grant]};
                r_rr_ptr    <= (w_grant == 3'(NUM_CH - 1)) ? 3'd0 : w_grant + 3'd1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if (|w_drop_evt) r_drop_any <= 1'b1;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign drop_any_o  = r_drop_any;

endmodule
`default_nettype wire
